shift_cmd_pipe: RTL and testbench

Command-queue and result-register stage wrapped around the combinational barrel shifter. Accepts shift commands (data, control, amount) over a valid/ready handshake and buffers them in a small FIFO. Presents the head command to the shifter, then captures the shifter's result into a registered valid/ready output. It decouples upstream producers from downstream consumers and sustains one shift per cycle under no backpressure.

---
 rtl/shift_cmd_pipe.sv | 171 +++++++++++++++++
 tb/tb_shift_cmd_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_pipe.sv
// Command FIFO plus registered result stage around an external barrel shifter.
// Optional SHIFT_CMD_PIPE_DROP_EN: drop illegal commands instead of flagging them.
module shift_cmd_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [WIDTH-1:0]           i_cmd_data,
  input  logic [2:0]                 i_cmd_ctrl,
  input  logic [$clog2(WIDTH):0]     i_cmd_amount,
  output logic [WIDTH-1:0]           o_sh_data,
  output logic [2:0]                 o_sh_ctrl,
  output logic [$clog2(WIDTH):0]     o_sh_amount,
  input  logic [WIDTH-1:0]           i_sh_result,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [WIDTH-1:0]           o_res_data,
  output logic                       o_res_err,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [7:0]                 o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(WIDTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       ctrl;
    logic [SW-1:0]    amt;
  } cmd_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } res_st_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  res_st_t       r_state;
  logic [WIDTH-1:0] r_res_data;
  logic          r_res_err;

  cmd_t          w_in;
  cmd_t          w_head;
  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_drop;
  logic          w_illegal;
  logic          w_err_nxt;
  logic          w_slot_free;

  assign w_in.data = i_cmd_data;
  assign w_in.ctrl = i_cmd_ctrl;
  assign w_in.amt  = i_cmd_amount;

  assign w_nonempty  = (r_count != '0);
  assign o_cmd_ready = (r_count < CW'(DEPTH));
  assign w_push      = i_cmd_valid && o_cmd_ready;

  // Head is forced to zero when empty so the shifter sees a quiet input.
  assign w_head    = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign w_illegal = w_head.ctrl[2] & w_head.ctrl[0];

  assign o_sh_data   = w_head.data;
  assign o_sh_ctrl   = w_head.ctrl;
  assign o_sh_amount = w_head.amt;

  assign o_res_valid = (r_state == S_FULL);
  assign w_slot_free = !o_res_valid || i_res_ready;

`ifdef SHIFT_CMD_PIPE_DROP_EN
  // Illegal heads leave regardless of the result stall.
  assign w_drop    = w_nonempty && w_illegal;
  assign w_capture = w_nonempty && !w_illegal && w_slot_free;
  assign w_err_nxt = 1'b0;
`else
  assign w_drop    = 1'b0;
  assign w_capture = w_nonempty && w_slot_free;
  assign w_err_nxt = w_illegal;
`endif

  assign w_pop = w_capture || w_drop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_EMPTY;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_capture) begin
            r_state    <= S_FULL;
            r_res_data <= w_illegal ? w_head.data : i_sh_result;
            r_res_err  <= w_err_nxt;
          end
        end
        S_FULL: begin
          if (w_capture) begin
            r_res_data <= w_illegal ? w_head.data : i_sh_result;
            r_res_err  <= w_err_nxt;
          end else if (i_res_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_res_data = r_res_data;
  assign o_res_err  = r_res_err;
  assign o_count    = r_count;

`ifdef SHIFT_CMD_PIPE_DROP_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_shift_cmd_pipe.sv
// Bench for shift_cmd_pipe: queue-level reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_shift_cmd_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [7:0] i_cmd_data = '0;
  logic [2:0] i_cmd_ctrl = '0;
  logic [3:0] i_cmd_amount = '0;
  logic [7:0] o_sh_data;
  logic [2:0] o_sh_ctrl;
  logic [3:0] o_sh_amount;
  logic [7:0] i_sh_result;
  logic       o_res_valid;
  logic       i_res_ready = 1'b0;
  logic [7:0] o_res_data;
  logic       o_res_err;
  logic [2:0] o_count;
  logic [7:0] o_drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  shift_cmd_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_data(i_cmd_data),
    .i_cmd_ctrl(i_cmd_ctrl),
    .i_cmd_amount(i_cmd_amount),
    .o_sh_data(o_sh_data),
    .o_sh_ctrl(o_sh_ctrl),
    .o_sh_amount(o_sh_amount),
    .i_sh_result(i_sh_result),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_data(o_res_data),
    .o_res_err(o_res_err),
    .o_count(o_count),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] shf(input logic [7:0] d,
                                     input logic [2:0] c,
                                     input logic [3:0] a);
    logic [15:0] dd;
    logic [2:0]  r;
    dd = {d, d};
    r = a[2:0];
    shf = d;
    case (c)
      3'd1: shf = (a >= 4'd8) ? 8'h00 : (d >> a);
      3'd2: shf = 8'($signed(d) >>> a);
      3'd3: begin dd = dd >> r; shf = dd[7:0]; end
      3'd4: shf = (a >= 4'd8) ? 8'h00 : (d << a);
      3'd6: begin dd = dd << r; shf = dd[15:8]; end
      default: shf = d;
    endcase
  endfunction

  // External combinational shifter
  assign i_sh_result = shf(o_sh_data, o_sh_ctrl, o_sh_amount);

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", n, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] c;
    logic [3:0] a;
  } cmd_t;

  cmd_t       m_q[$];
  cmd_t       m_h;
  cmd_t       m_nc;
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = '0;
  logic       m_re = 1'b0;
  int         m_drop = 0;
  logic       m_push;
  logic       m_ill;

  // Transaction-level reference: FIFO queue feeding a one-entry result slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rv = 1'b0;
      m_rd = '0;
      m_re = 1'b0;
      m_drop = 0;
    end else begin
      m_push = i_cmd_valid && (m_q.size() < D);
      m_nc.d = i_cmd_data;
      m_nc.c = i_cmd_ctrl;
      m_nc.a = i_cmd_amount;
      if (m_q.size() > 0) begin
        m_h = m_q[0];
        m_ill = (m_h.c == 3'd5) || (m_h.c == 3'd7);
`ifdef SHIFT_CMD_PIPE_DROP_EN
        if (m_ill) begin
          void'(m_q.pop_front());
          if (m_drop < 255) m_drop++;
          if (m_rv && i_res_ready) m_rv = 1'b0;
        end else if (!m_rv || i_res_ready) begin
          m_rd = shf(m_h.d, m_h.c, m_h.a);
          m_re = 1'b0;
          m_rv = 1'b1;
          void'(m_q.pop_front());
        end
`else
        if (!m_rv || i_res_ready) begin
          m_rd = m_ill ? m_h.d : shf(m_h.d, m_h.c, m_h.a);
          m_re = m_ill;
          m_rv = 1'b1;
          void'(m_q.pop_front());
        end
`endif
      end else if (m_rv && i_res_ready) begin
        m_rv = 1'b0;
      end
      if (m_push) m_q.push_back(m_nc);
    end
  end

  logic [7:0] got[$];
  logic       got_err[$];
  int         got_cyc[$];
  logic [7:0] e_d;
  logic [2:0] e_c;
  logic [3:0] e_a;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      e_d = '0; e_c = '0; e_a = '0;
      if (m_q.size() > 0) begin
        e_d = m_q[0].d; e_c = m_q[0].c; e_a = m_q[0].a;
      end
      chk("ready", o_cmd_ready, m_q.size() < D);
      chk("count", o_count, m_q.size());
      chk("count_max", o_count <= 3'(D), 1);
      chk("sh_data", o_sh_data, e_d);
      chk("sh_ctrl", o_sh_ctrl, e_c);
      chk("sh_amt", o_sh_amount, e_a);
      chk("res_valid", o_res_valid, m_rv);
      if (m_rv) begin
        chk("res_data", o_res_data, m_rd);
        chk("res_err", o_res_err, m_re);
      end
      chk("drop_cnt", o_drop_cnt, m_drop);
      if (o_res_valid && i_res_ready) begin
        got.push_back(o_res_data);
        got_err.push_back(o_res_err);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] c,
                      input logic [3:0] a);
    i_cmd_data = d;
    i_cmd_ctrl = c;
    i_cmd_amount = a;
    i_cmd_valid = 1'b1;
  endtask

  task automatic clear_log();
    got.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  logic acc;
  int   guard;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_res_valid, 0);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_sh", o_sh_data, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single rotate right
    i_res_ready = 1'b1;
    send(8'hB4, 3'd3, 4'd2);
    tick();
    i_cmd_valid = 1'b0;
    chk("rot_lat1_valid", o_res_valid, 0);
    chk("rot_lat1_count", o_count, 1);
    tick();
    chk("rot_valid", o_res_valid, 1);
    chk("rot_data", o_res_data, 8'h2D);
    chk("rot_err", o_res_err, 0);
    repeat (3) tick();

    // Back-to-back, no bubbles
    clear_log();
    send(8'h81, 3'd4, 4'd1); tick();
    send(8'h80, 3'd2, 4'd3); tick();
    send(8'hF0, 3'd1, 4'd4); tick();
    i_cmd_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_0", got[0], 8'h02);
      chk("b2b_1", got[1], 8'hF0);
      chk("b2b_2", got[2], 8'h0F);
      chk("b2b_gap0", got_cyc[1] - got_cyc[0], 1);
      chk("b2b_gap1", got_cyc[2] - got_cyc[1], 1);
    end

    // Backpressure: DEPTH in FIFO plus one in the result register
    clear_log();
    i_res_ready = 1'b0;
    send(8'h11, 3'd0, 4'd0); tick();
    send(8'h01, 3'd4, 4'd3); tick();
    send(8'h80, 3'd1, 4'd7); tick();
    send(8'h0F, 3'd6, 4'd4); tick();
    send(8'hC0, 3'd2, 4'd1); tick();
    send(8'h33, 3'd0, 4'd0); tick();
    i_cmd_valid = 1'b0;
    chk("bp_count", o_count, 4);
    chk("bp_ready", o_cmd_ready, 0);
    chk("bp_valid", o_res_valid, 1);
    i_res_ready = 1'b1;
    repeat (8) tick();
    chk("bp_n", got.size(), 5);
    if (got.size() == 5) begin
      chk("bp_0", got[0], 8'h11);
      chk("bp_1", got[1], 8'h08);
      chk("bp_2", got[2], 8'h01);
      chk("bp_3", got[3], 8'hF0);
      chk("bp_4", got[4], 8'hE0);
    end

    // Illegal ctrl code
    clear_log();
    send(8'h5A, 3'd7, 4'd0); tick();
    i_cmd_valid = 1'b0;
    repeat (3) tick();
`ifdef SHIFT_CMD_PIPE_DROP_EN
    chk("ill_n", got.size(), 0);
    chk("ill_drop", o_drop_cnt, 1);
`else
    chk("ill_n", got.size(), 1);
    if (got.size() == 1) begin
      chk("ill_data", got[0], 8'h5A);
      chk("ill_err", got_err[0], 1);
    end
    chk("ill_drop", o_drop_cnt, 0);
`endif

    // Asynchronous reset mid-stream with 3 queued commands
    i_res_ready = 1'b0;
    send(8'hA1, 3'd0, 4'd0); tick();
    send(8'hA2, 3'd0, 4'd0); tick();
    send(8'hA3, 3'd0, 4'd0); tick();
    send(8'hA4, 3'd0, 4'd0); tick();
    i_cmd_valid = 1'b0;
    chk("mr_pre_count", o_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_count", o_count, 0);
    chk("mr_valid", o_res_valid, 0);
    chk("mr_ready", o_cmd_ready, 1);
    chk("mr_sh", o_sh_data, 0);
    chk("mr_drop", o_drop_cnt, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    clear_log();
    i_res_ready = 1'b1;
    send(8'h01, 3'd0, 4'd0); tick();
    i_cmd_valid = 1'b0;
    repeat (3) tick();
    chk("mr_n", got.size(), 1);
    if (got.size() >= 1) chk("mr_first", got[0], 8'h01);

    // Wrap-around stream with random backpressure
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 3'($urandom), 4'($urandom));
      guard = 0;
      do begin
        i_res_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = o_cmd_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("wrap_timeout", guard, 0);
    end
    i_cmd_valid = 1'b0;
    i_res_ready = 1'b1;
    repeat (20) tick();
    chk("wrap_count", o_count, 0);
    chk("wrap_valid", o_res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
